cla_sub_seq_64: RTL and testbench
=================================

# cla_sub_seq_64

Multi-cycle 64-bit subtractor computing `diff = a - b - bin` one 16-bit carry-lookahead slice per clock. It is the inverse-direction companion to the team's registered 64-bit CLA adders. It uses a valid/ready handshake on both sides so it can sit behind an operand-issue stage and in front of a result consumer. It trades throughput for a short critical path, with one 16-bit slice per cycle instead of a full 64-bit chain.

## Interface
- `WIDTH`, 64: operand width; must be a multiple of `SLICE`.
- `SLICE`, 16: bits processed per cycle.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `in_valid` input, 1 bit: operands `a`, `b`, `bin` are valid.
- `in_ready` output, 1 bit: block can accept an operation.
- `a` input, WIDTH bits: minuend.
- `b` input, WIDTH bits: subtrahend.
- `bin` input, 1 bit: borrow-in.
- `out_valid` output, 1 bit: result registers hold a completed result.
- `out_ready` input, 1 bit: consumer takes the result.
- `diff_r` output, WIDTH bits: registered difference, modulo 2^WIDTH.
- `bout_r` output, 1 bit: registered borrow-out; 1 exactly when unsigned `a < b + bin`.
- `eq_r` output, 1 bit: registered; 1 when `diff_r == 0`.

## Operation
- Arithmetic: `a + ~b + ~bin` through SLICE-wide CLA slices.
  - Running carry register `c` is initialised to `~bin`.
  - `bout_r = ~c_final`.
- States:
  - IDLE: `in_ready=1`.
  - BUSY: `in_ready=0`, `out_valid=0`.
  - DONE: `in_ready=0`, `out_valid=1`.
- IDLE, on `in_valid & in_ready`:
  - Latch `a`, `b` into operand registers.
  - Set `c <= ~bin`, slice index `idx <= 0`, zero-accumulator `z <= 1`.
  - Go to BUSY.
- BUSY, each cycle:
  - `diff_r[idx*SLICE +: SLICE] <=` slice sum.
  - `c <=` slice carry-out.
  - `z <= z & (slice sum == 0)`.
  - `idx <= idx+1`.
  - At `idx == WIDTH/SLICE-1`: go to DONE, set `bout_r <= ~carry_out`, set `eq_r <=` final `z`.
- DONE:
  - `diff_r`, `bout_r`, `eq_r` stay stable.
  - `in_valid` is ignored.
  - On `out_ready`: go to IDLE.
- `out_ready` is ignored outside DONE.
- `diff_r`, `bout_r` and `eq_r` keep their last values after leaving DONE. They are overwritten only slice-by-slice in the next BUSY.
- No pipelining of operations: one operation in flight at a time.

## Timing
- Reset values:
  - `diff_r=0`, `bout_r=0`, `eq_r=0`, `out_valid=0`.
  - State IDLE, so `in_ready=1`.
  - `idx=0`, `c=0`.
- `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from inputs.
- Latency, counted from the accept edge E0: slices are written at E1..E4 (WIDTH/SLICE edges). `out_valid` is high from E4.
- Minimum initiation interval: WIDTH/SLICE + 2 = 6 cycles (accept, 4 BUSY edges, DONE-handshake edge). The next accept can occur the edge after the DONE handshake.
- The result is held indefinitely while `out_ready=0`.
- Reset asserted mid-BUSY or in DONE:
  - All registers return to reset values immediately, without waiting for a clock edge.
  - The in-flight operation is discarded; no partial result is presented.
- Simultaneous `in_valid` and the DONE handshake: the input is not accepted on that edge, because `in_ready=0`.

## Structure
- Shared package holds:
  - `WIDTH`/`SLICE` defaults.
  - `NSLICE = WIDTH/SLICE`.
  - Index width `$clog2(NSLICE)`.
  - State enum {IDLE, BUSY, DONE}.
- One sub-module `cla_sub_slice`:
  - SLICE-bit p/g generation on `a` and `~b`.
  - Lookahead carry chain.
  - Outputs: sum and carry-out.
  - Purely combinational, instantiated once.
  - The top-level multiplexes operand slices by `idx`.

## Test plan
- Accept `a=5`, `b=3`, `bin=0` at E0 → `out_valid` rises at E4; `diff_r=2`, `bout_r=0`, `eq_r=0`; `in_ready` is low E1 through the DONE handshake.
- `a=0`, `b=0`, `bin=1` → `diff_r=64'hFFFF_FFFF_FFFF_FFFF`, `bout_r=1`, `eq_r=0`. `a=0`, `b=1`, `bin=0` → same result.
- `a=b=64'h1234_5678_9ABC_DEF0`, `bin=0` → `diff_r=0`, `eq_r=1`, `bout_r=0`.
- `a=64'h0001_0000_0000_0000`, `b=1` → borrow ripples across slices 0–2; `diff_r=64'h0000_FFFF_FFFF_FFFF`, `bout_r=0`.
- Result backpressure: hold `out_ready=0` for 10 cycles while driving `in_valid=1` with new operands → `out_valid` stays 1, `diff_r` is unchanged, nothing is accepted. Raise `out_ready` → IDLE next edge, and the new operands are accepted on the following edge.
- Assert `rst` asynchronously during BUSY at `idx=2` → all outputs are 0 and `in_ready=1` before the next clock edge. A subsequent `a=10`, `b=4` yields `diff_r=6`.

Source files
------------

// File: rtl/cla_sub_seq_64_pkg.sv
// Shared parameters, index-width helper and FSM state type for the sequential
// 64-bit CLA subtractor.
package cla_sub_seq_64_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned SLICE_DEF = 16;
  localparam int unsigned NSLICE    = WIDTH_DEF / SLICE_DEF;

  // Keep at least one bit so a single-slice build still has a legal index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(NSLICE);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

endpackage

// File: rtl/cla_sub_slice.sv
// One combinational SLICE-bit carry-lookahead stage computing a + ~b + cin.
module cla_sub_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] p, g;
  logic [SLICE:0]   c;

  assign p = a ^ ~b;
  assign g = a & ~b;

  // Parallel-prefix group generate/propagate; bit i ends up covering [i:0].
  always_comb begin
    logic [SLICE-1:0] gk, pk, gn, pn;
    gk = g;
    pk = p;
    gn = g;
    pn = p;
    for (int d = 1; d < int'(SLICE); d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < int'(SLICE); i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    c[0] = cin;
    for (int i = 0; i < int'(SLICE); i++) begin
      c[i+1] = gk[i] | (pk[i] & cin);
    end
  end

  assign sum  = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

// File: rtl/cla_sub_seq_64.sv
// Multi-cycle subtractor: diff = a - b - bin, one CLA slice per clock behind a
// valid/ready handshake on both sides.
module cla_sub_seq_64
  import cla_sub_seq_64_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_r,
  output logic             bout_r,
  output logic             eq_r
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned IW = idx_width(NS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q, z_q;
  logic [IW-1:0]    idx_q;
  logic [31:0]      base;
  logic [SLICE-1:0] a_sl, b_sl, sum;
  logic             cout, last;

  assign base = 32'(idx_q) * SLICE;
  assign a_sl = a_q[base +: SLICE];
  assign b_sl = b_q[base +: SLICE];
  assign last = (idx_q == IW'(NS - 1));

  cla_sub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .cin (c_q),
    .sum (sum),
    .cout(cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StBusy;
      StBusy: if (last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      idx_q   <= '0;
      diff_r  <= '0;
      bout_r  <= 1'b0;
      eq_r    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        c_q   <= ~bin;
        idx_q <= '0;
        z_q   <= 1'b1;
      end
      if (state_q == StBusy) begin
        diff_r[base +: SLICE] <= sum;
        c_q   <= cout;
        z_q   <= z_q & ~|sum;
        idx_q <= idx_q + IW'(1);
        // Outputs other than diff_r only change once the whole word is known.
        if (last) begin
          bout_r <= ~cout;
          eq_r   <= z_q & ~|sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_seq_64.sv
// Self-checking bench for cla_sub_seq_64: arithmetic/handshake model plus
// directed vectors with literal expectations.
module tb_cla_sub_seq_64;

  localparam int unsigned NSL = 4;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [63:0] a, b;
  logic        bin;
  logic        out_valid, out_ready;
  logic [63:0] diff_r;
  logic        bout_r, eq_r;

  int checks = 0;
  int errors = 0;

  cla_sub_seq_64 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff_r   (diff_r),
    .bout_r   (bout_r),
    .eq_r     (eq_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 = waiting for operands, 1 = computing (countdown), 2 = holding result.
  int          m_phase;
  int          m_cnt;
  logic [63:0] m_a, m_b;
  logic        m_bin;
  logic [63:0] e_diff;
  logic        e_bout, e_eq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_bin   <= 1'b0;
      e_diff  <= '0;
      e_bout  <= 1'b0;
      e_eq    <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_a     <= a;
          m_b     <= b;
          m_bin   <= bin;
          m_cnt   <= NSL;
          m_phase <= 1;
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_phase <= 2;
            e_diff  <= m_a - m_b - 64'(m_bin);
            e_bout  <= ({1'b0, m_a} < ({1'b0, m_b} + 65'(m_bin)));
            e_eq    <= ((m_a - m_b - 64'(m_bin)) == 64'd0);
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (in_ready !== (m_phase == 0)) begin
      errors++;
      $display("FAIL model_in_ready got=%b want=%b t=%0t", in_ready, (m_phase == 0), $time);
    end
    checks++;
    if (out_valid !== (m_phase == 2)) begin
      errors++;
      $display("FAIL model_out_valid got=%b want=%b t=%0t", out_valid, (m_phase == 2), $time);
    end
    if (m_phase != 1) begin
      checks++;
      if (diff_r !== e_diff || bout_r !== e_bout || eq_r !== e_eq) begin
        errors++;
        $display("FAIL model_result got=%h/%b/%b want=%h/%b/%b t=%0t",
                 diff_r, bout_r, eq_r, e_diff, e_bout, e_eq, $time);
      end
    end
  end

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic ibin);
    @(posedge clk);
    #1;
    check1("ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    bin      = ibin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called at accept edge + 1; out_valid must appear after the 4th following edge.
  task automatic wait_result(input string name, input logic [63:0] ed, input logic eb,
                             input logic ee);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1({name, "_latency"}, 64'(n), 64'd5);
    check1({name, "_diff"}, diff_r, ed);
    check1({name, "_bout"}, 64'(bout_r), 64'(eb));
    check1({name, "_eq"}, 64'(eq_r), 64'(ee));
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check1("idle_after_handshake", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_in_ready", 64'(in_ready), 64'd1);
    check1("reset_out_valid", 64'(out_valid), 64'd0);
    check1("reset_diff", diff_r, 64'd0);
    rst = 1'b0;

    issue(64'd5, 64'd3, 1'b0);
    check1("busy_in_ready", 64'(in_ready), 64'd0);
    wait_result("small", 64'd2, 1'b0, 1'b0);
    handshake();

    issue(64'd0, 64'd0, 1'b1);
    wait_result("bin_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    handshake();

    issue(64'd0, 64'd1, 1'b0);
    wait_result("b_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    handshake();

    issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_result("equal", 64'd0, 1'b0, 1'b1);
    handshake();

    issue(64'h0001_0000_0000_0000, 64'd1, 1'b0);
    wait_result("ripple", 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    handshake();

    // Backpressure: new operands offered while the result is held.
    issue(64'd100, 64'd1, 1'b0);
    wait_result("hold", 64'd99, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = 64'd1000;
    b        = 64'd1;
    bin      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("hold_valid", 64'(out_valid), 64'd1);
      check1("hold_diff", diff_r, 64'd99);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check1("no_accept_on_handshake", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1("accept_after_handshake", 64'(in_ready), 64'd0);
    wait_result("after_hold", 64'd998, 1'b0, 1'b0);
    handshake();

    // Asynchronous reset while the third slice is being worked on.
    issue(64'hFFFF_0000_FFFF_0000, 64'h0000_1111_0000_1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check1("async_in_ready", 64'(in_ready), 64'd1);
    check1("async_out_valid", 64'(out_valid), 64'd0);
    check1("async_diff", diff_r, 64'd0);
    check1("async_flags", {62'd0, bout_r, eq_r}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(64'd10, 64'd4, 1'b0);
    wait_result("post_reset", 64'd6, 1'b0, 1'b0);
    handshake();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
